line_debouncer: RTL and testbench

- Filters a noisy, asynchronous single-bit input (push-button, strap or probe line) into a clean, synchronous level for downstream control logic.
- Two-or-more-stage synchroniser followed by a consecutive-sample stability counter.
- Output changes only after the synchronised input holds the new level for STABLE_CYCLES consecutive clocks.
- Also provides one-cycle edge pulses on each accepted transition.

---
 rtl/line_debouncer.sv | 78 +++++++
 tb/tb_line_debouncer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/line_debouncer.sv
// Debounces an asynchronous single-bit line. The line passes through a flop synchroniser,
// then a run counter accepts a new level only after it has been held for STABLE_CYCLES clocks.
module line_debouncer #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic        INIT_LEVEL    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic debounced_line,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic stable
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_q;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   debounced_reg;
    logic                   debounced_next;
    logic                   rise_reg;
    logic                   rise_next;
    logic                   fall_reg;
    logic                   fall_next;

    // Plain shift chain: no logic between stages, so metastability has a full clock to settle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], line};
        end
    end

    assign sync_q = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg       <= '0;
            debounced_reg <= INIT_LEVEL;
            rise_reg      <= 1'b0;
            fall_reg      <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            debounced_reg <= debounced_next;
            rise_reg      <= rise_next;
            fall_reg      <= fall_next;
        end
    end

    // Any sample agreeing with the current output restarts the run, which is what rejects glitches.
    always_comb begin
        cnt_next       = '0;
        debounced_next = debounced_reg;
        rise_next      = 1'b0;
        fall_next      = 1'b0;
        if (sync_q != debounced_reg) begin
            if (cnt_reg == CNT_LAST) begin
                debounced_next = sync_q;
                rise_next      = sync_q;
                fall_next      = ~sync_q;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    assign debounced_line = debounced_reg;
    assign rise_pulse     = rise_reg;
    assign fall_pulse     = fall_reg;
    assign stable         = (sync_q == debounced_reg);

endmodule

// File: tb/tb_line_debouncer.sv
// Directed bench for line_debouncer: a queue/window model checked every cycle,
// plus literal latency and pulse-count expectations.
module tb_line_debouncer;

    localparam int unsigned SC = 16;
    localparam int unsigned SS = 2;
    localparam logic        INIT = 1'b1;
    localparam int          LATENCY = 18;

    logic clk = 1'b0;
    logic reset;
    logic line;
    logic debounced_line;
    logic rise_pulse;
    logic fall_pulse;
    logic stable;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int rise_seen = 0;
    int fall_seen = 0;
    bit run_cmp   = 0;

    line_debouncer #(
        .STABLE_CYCLES(SC),
        .SYNC_STAGES  (SS),
        .INIT_LEVEL   (INIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .line          (line),
        .debounced_line(debounced_line),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse),
        .stable        (stable)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: sq holds the last SS line samples (front = synchroniser output);
    // win holds synchronised samples since the last reset/flip; a flip happens
    // once the newest SC of them all disagree with the current output.
    logic m_out, m_rise, m_fall;
    logic sq[$];
    logic win[$];

    always @(posedge clk or posedge reset) begin
        logic s;
        bit   all_diff;
        if (reset) begin
            m_out  = INIT;
            m_rise = 1'b0;
            m_fall = 1'b0;
            sq.delete();
            for (int i = 0; i < SS; i++) sq.push_back(INIT);
            win.delete();
        end else begin
            s = sq.pop_front();
            sq.push_back(line);
            m_rise = 1'b0;
            m_fall = 1'b0;
            win.push_back(s);
            if (win.size() > SC) void'(win.pop_front());
            all_diff = (win.size() == SC);
            foreach (win[i]) if (win[i] == m_out) all_diff = 0;
            if (all_diff) begin
                m_out  = s;
                m_rise = s;
                m_fall = !s;
                win.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("debounced_line", int'(debounced_line), int'(m_out));
            check("rise_pulse", int'(rise_pulse), int'(m_rise));
            check("fall_pulse", int'(fall_pulse), int'(m_fall));
            check("stable", int'(stable), int'(sq[0] == m_out));
            check("pulse_exclusive", int'(rise_pulse & fall_pulse), 0);
            if (rise_pulse) rise_seen++;
            if (fall_pulse) fall_seen++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new level just after a negedge and count edges (inclusive of the
    // first sampling edge) until the output follows; also pin the edge pulse.
    task automatic drive_and_measure(input string name, input logic lvl);
        int n = 0;
        line = lvl;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (debounced_line == lvl) break;
        end
        check({name, "_latency"}, n, LATENCY);
        check({name, "_pulse"}, int'(lvl ? rise_pulse : fall_pulse), 1);
        @(negedge clk);
    endtask

    initial begin
        int r0, f0;
        reset = 1'b0;
        line  = 1'b1;
        #1 reset = 1'b1;
        #1 run_cmp = 1;
        #198;
        @(negedge clk);
        reset = 1'b0;
        check("reset_level", int'(debounced_line), 1);
        check("reset_stable", int'(stable), 1);
        cycles(50);
        check("idle_no_pulses", rise_seen + fall_seen, 0);

        // Clean fall, long hold, clean rise
        drive_and_measure("fall", 1'b0);
        cycles(280);
        drive_and_measure("rise", 1'b1);
        cycles(30);
        check("clean_pulse_counts", rise_seen * 10 + fall_seen, 11);

        // Glitch of 10 clocks is shorter than SC and must be swallowed
        r0 = rise_seen; f0 = fall_seen;
        line = 1'b0;
        cycles(10);
        line = 1'b1;
        cycles(40);
        check("glitch_level", int'(debounced_line), 1);
        check("glitch_pulses", (rise_seen - r0) + (fall_seen - f0), 0);

        // Bounce every 3 clocks, then settle low: exactly one fall
        f0 = fall_seen; r0 = rise_seen;
        for (int seg = 0; seg < 12; seg++) begin
            line = seg[0];
            cycles(3);
        end
        drive_and_measure("bounce", 1'b0);
        cycles(20);
        check("bounce_falls", fall_seen - f0, 1);
        check("bounce_rises", rise_seen - r0, 0);

        // Reset mid-count: output snaps back to INIT, then counts afresh
        drive_and_measure("restore", 1'b1);
        cycles(5);
        r0 = rise_seen;
        line = 1'b0;
        cycles(10);
        check("pre_reset_level", int'(debounced_line), 1);
        #3 reset = 1'b1;
        #1 check("reset_async_level", int'(debounced_line), 1);
        check("reset_async_stable", int'(stable), 1);
        cycles(3);
        reset = 1'b0;
        drive_and_measure("post_reset", 1'b0);
        check("reset_no_rise", rise_seen - r0, 0);
        cycles(10);

        run_cmp = 0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
